// File: rtl/wbgpiox_pkg.sv
// Shared definitions for the wbgpiox GPIO controller: register map,
// pin-count limits and the Wishbone byte-select helper.
package wbgpiox_pkg;

   localparam int unsigned MAX_NIN  = 32;
   localparam int unsigned MAX_NOUT = 32;
   localparam int unsigned BUS_W    = 32;

   typedef enum logic [2:0] {
      ADDR_IN   = 3'd0,
      ADDR_OUT  = 3'd1,
      ADDR_SET  = 3'd2,
      ADDR_CLR  = 3'd3,
      ADDR_RISE = 3'd4,
      ADDR_FALL = 3'd5,
      ADDR_PEND = 3'd6,
      ADDR_PSC  = 3'd7
   } wb_addr_e;

   function automatic logic [BUS_W-1:0] sel_mask(input logic [3:0] sel);
      return {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
   endfunction

endpackage

// File: rtl/wbgpiox_debounce.sv
// Input conditioning: 2-FF synchroniser, prescaled sample tick and a
// two-tick stability filter producing the debounced IN vector.
module wbgpiox_debounce
   import wbgpiox_pkg::*;
#(
   parameter int unsigned NIN   = 16,
   parameter int unsigned PSC_W = 16
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic [NIN-1:0]   i_gpio,
   input  logic [PSC_W-1:0] i_reload,
   input  logic             i_load,
   output logic [NIN-1:0]   o_in,
   output logic [NIN-1:0]   o_in_next,
   output logic             o_tick
);

   (* ASYNC_REG = "TRUE" *) logic [NIN-1:0] sync1_q;
   (* ASYNC_REG = "TRUE" *) logic [NIN-1:0] s_q;
   logic [NIN-1:0]   sync1_d, s_d;
   logic [NIN-1:0]   prev_q, prev_d;
   logic [NIN-1:0]   in_q, in_d;
   logic [PSC_W-1:0] cnt_q, cnt_d;
   logic             tick;

   always_comb begin
      sync1_d = i_gpio;
      s_d     = sync1_q;
      tick    = (cnt_q == '0);
      prev_d  = prev_q;
      in_d    = in_q;
      if (tick) begin
         prev_d = s_q;
         // a bit follows s only where s agreed with the previous tick's sample
         in_d   = (in_q & (s_q ^ prev_q)) | (s_q & ~(s_q ^ prev_q));
      end
      o_in      = in_q;
      o_in_next = in_d;
      o_tick    = tick;
   end

   // Kept apart from the filter logic so i_reload (fed from the register
   // file) never shares a process with o_in_next (read by the register file).
   always_comb begin
      cnt_d = cnt_q - PSC_W'(1);
      if (i_load || tick) begin
         cnt_d = i_reload;
      end
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         sync1_q <= '0;
         s_q     <= '0;
         prev_q  <= '0;
         in_q    <= '0;
         cnt_q   <= '0;
      end else begin
         sync1_q <= sync1_d;
         s_q     <= s_d;
         prev_q  <= prev_d;
         in_q    <= in_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: rtl/wbgpiox.sv
// Wishbone GPIO controller: 8-word register file with atomic set/clear,
// debounced inputs and per-pin edge interrupts with W1C pending bits.
module wbgpiox
   import wbgpiox_pkg::*;
#(
   parameter int unsigned      NIN      = 16,
   parameter int unsigned      NOUT     = 16,
   parameter logic [NOUT-1:0]  DEFAULT  = '0,
   parameter int unsigned      PSC_W    = 16,
   parameter logic [PSC_W-1:0] PSC_INIT = '0
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              i_wb_cyc,
   input  logic              i_wb_stb,
   input  logic              i_wb_we,
   input  logic [2:0]        i_wb_addr,
   input  logic [BUS_W-1:0]  i_wb_data,
   input  logic [3:0]        i_wb_sel,
   output logic              o_wb_stall,
   output logic              o_wb_ack,
   output logic [BUS_W-1:0]  o_wb_data,
   input  logic [NIN-1:0]    i_gpio,
   output logic [NOUT-1:0]   o_gpio,
   output logic              o_int
);

   logic [NOUT-1:0]  out_q, out_d;
   logic [NIN-1:0]   rise_q, rise_d;
   logic [NIN-1:0]   fall_q, fall_d;
   logic [NIN-1:0]   pend_q, pend_d;
   logic [PSC_W-1:0] psc_q, psc_d;
   logic             ack_q, ack_d;
   logic [BUS_W-1:0] data_q, data_d;
   logic             int_q, int_d;

   logic [NIN-1:0]   in_q, in_next, edge_set;
   logic             tick;

   wb_addr_e         addr;
   logic             wr, psc_load, unused_bits;
   logic [BUS_W-1:0] mask, wdat, rd;
   logic [BUS_W-1:0] out_n, rise_n, fall_n, psc_n, w1c;

   wbgpiox_debounce #(
      .NIN   (NIN),
      .PSC_W (PSC_W)
   ) u_debounce (
      .i_clk     (i_clk),
      .i_reset   (i_reset),
      .i_gpio    (i_gpio),
      .i_reload  (psc_d),
      .i_load    (psc_load),
      .o_in      (in_q),
      .o_in_next (in_next),
      .o_tick    (tick)
   );

   always_comb begin
      addr     = wb_addr_e'(i_wb_addr);
      wr       = i_wb_stb & i_wb_we;
      mask     = sel_mask(i_wb_sel);
      wdat     = i_wb_data & mask;
      out_n    = BUS_W'(out_q);
      rise_n   = BUS_W'(rise_q);
      fall_n   = BUS_W'(fall_q);
      psc_n    = BUS_W'(psc_q);
      w1c      = '0;
      psc_load = 1'b0;

      if (wr) begin
         case (addr)
            ADDR_OUT:  out_n  = (out_n & ~mask) | wdat;
            ADDR_SET:  out_n  = out_n | wdat;
            ADDR_CLR:  out_n  = out_n & ~wdat;
            ADDR_RISE: rise_n = (rise_n & ~mask) | wdat;
            ADDR_FALL: fall_n = (fall_n & ~mask) | wdat;
            ADDR_PEND: w1c    = wdat;
            ADDR_PSC: begin
               psc_n    = (psc_n & ~mask) | wdat;
               psc_load = 1'b1;
            end
            default: ;
         endcase
      end

      out_d  = out_n[NOUT-1:0];
      rise_d = rise_n[NIN-1:0];
      fall_d = fall_n[NIN-1:0];
      psc_d  = psc_n[PSC_W-1:0];

      edge_set = '0;
      if (tick) begin
         edge_set = (in_next & ~in_q & rise_q) | (~in_next & in_q & fall_q);
      end
      // OR-ing the new edges in after the clear lets a coincident edge win
      pend_d = (pend_q & ~w1c[NIN-1:0]) | edge_set;

      rd = '0;
      case (addr)
         ADDR_IN:   rd = BUS_W'(in_q);
         ADDR_OUT:  rd = BUS_W'(out_q);
         ADDR_RISE: rd = BUS_W'(rise_q);
         ADDR_FALL: rd = BUS_W'(fall_q);
         ADDR_PEND: rd = BUS_W'(pend_q);
         ADDR_PSC:  rd = BUS_W'(psc_q);
         default:   rd = '0;
      endcase

      ack_d  = i_wb_stb;
      data_d = i_wb_stb ? rd : data_q;
      int_d  = |pend_q;

      unused_bits = ^{out_n, rise_n, fall_n, psc_n, w1c, i_wb_cyc};
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         out_q  <= DEFAULT;
         rise_q <= '0;
         fall_q <= '0;
         pend_q <= '0;
         psc_q  <= PSC_INIT;
         ack_q  <= 1'b0;
         data_q <= '0;
         int_q  <= 1'b0;
      end else begin
         out_q  <= out_d;
         rise_q <= rise_d;
         fall_q <= fall_d;
         pend_q <= pend_d;
         psc_q  <= psc_d;
         ack_q  <= ack_d;
         data_q <= data_d;
         int_q  <= int_d;
      end
   end

   assign o_wb_stall = 1'b0;
   assign o_wb_ack   = ack_q;
   assign o_wb_data  = data_q;
   assign o_gpio     = out_q;
   assign o_int      = int_q;

endmodule

// File: tb/tb_wbgpiox.sv
// Scoreboard bench for wbgpiox: bus tasks queue expected read data, a
// negedge monitor pops and compares on every ack.
module tb_wbgpiox;

   logic        i_clk = 1'b0;
   logic        i_reset = 1'b1;
   logic        i_wb_cyc = 1'b0;
   logic        i_wb_stb = 1'b0;
   logic        i_wb_we = 1'b0;
   logic [2:0]  i_wb_addr = 3'd0;
   logic [31:0] i_wb_data = 32'h0;
   logic [3:0]  i_wb_sel = 4'h0;
   logic        o_wb_stall;
   logic        o_wb_ack;
   logic [31:0] o_wb_data;
   logic [15:0] i_gpio = 16'h0;
   logic [15:0] o_gpio;
   logic        o_int;

   typedef struct {
      logic        chk;
      logic [31:0] exp;
      string       name;
   } sb_t;

   sb_t sb[$];
   sb_t mon_e;
   int  n_chk = 0;
   int  n_fail = 0;

   always #5 i_clk = ~i_clk;

   wbgpiox #(
      .NIN      (16),
      .NOUT     (16),
      .DEFAULT  (16'h00A5),
      .PSC_W    (16),
      .PSC_INIT (16'h0000)
   ) dut (
      .i_clk      (i_clk),
      .i_reset    (i_reset),
      .i_wb_cyc   (i_wb_cyc),
      .i_wb_stb   (i_wb_stb),
      .i_wb_we    (i_wb_we),
      .i_wb_addr  (i_wb_addr),
      .i_wb_data  (i_wb_data),
      .i_wb_sel   (i_wb_sel),
      .o_wb_stall (o_wb_stall),
      .o_wb_ack   (o_wb_ack),
      .o_wb_data  (o_wb_data),
      .i_gpio     (i_gpio),
      .o_gpio     (o_gpio),
      .o_int      (o_int)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Called just after a rising edge; the request is registered on the next edge.
   task automatic bus(input logic we, input logic [2:0] a, input logic [31:0] d, input logic [3:0] sel);
      i_wb_cyc  = 1'b1;
      i_wb_stb  = 1'b1;
      i_wb_we   = we;
      i_wb_addr = a;
      i_wb_data = d;
      i_wb_sel  = sel;
      @(posedge i_clk); #1;
      i_wb_cyc  = 1'b0;
      i_wb_stb  = 1'b0;
      i_wb_we   = 1'b0;
   endtask

   task automatic rd(input logic [2:0] a, input logic [31:0] exp, input string name);
      sb.push_back('{1'b1, exp, name});
      bus(1'b0, a, 32'h0, 4'hF);
   endtask

   task automatic wr(input logic [2:0] a, input logic [31:0] d, input logic [3:0] sel);
      sb.push_back('{1'b0, 32'h0, "wr"});
      bus(1'b1, a, d, sel);
   endtask

   task automatic cycles(input int n);
      repeat (n) @(posedge i_clk);
      #1;
   endtask

   always @(negedge i_clk) begin
      if (o_wb_ack) begin
         if (sb.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_ack: got ack=1 expected ack=0");
         end else begin
            mon_e = sb.pop_front();
            if (mon_e.chk) check(mon_e.name, o_wb_data, mon_e.exp);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected $finish");
      $fatal(1);
   end

   initial begin
      cycles(3);
      check("rst_gpio", {16'h0, o_gpio}, 32'h0000_00A5);
      check("rst_ack", {31'h0, o_wb_ack}, 32'h0);
      check("rst_int", {31'h0, o_int}, 32'h0);
      i_reset = 1'b0;
      cycles(1);
      check("stall", {31'h0, o_wb_stall}, 32'h0);

      rd(3'd1, 32'h0000_00A5, "rst_out");
      rd(3'd4, 32'h0, "rst_rise");
      rd(3'd5, 32'h0, "rst_fall");
      rd(3'd6, 32'h0, "rst_pend");
      rd(3'd7, 32'h0, "rst_psc");
      rd(3'd0, 32'h0, "rst_in");

      // set / clear / byte-select writes
      wr(3'd1, 32'h0, 4'hF);
      wr(3'd2, 32'h0003, 4'hF);
      wr(3'd3, 32'h0001, 4'hF);
      rd(3'd1, 32'h0000_0002, "set_clr");
      rd(3'd2, 32'h0, "set_reads0");
      rd(3'd3, 32'h0, "clr_reads0");
      wr(3'd1, 32'hFFFF, 4'b0001);
      rd(3'd1, 32'h0000_00FF, "sel_byte0");
      check("gpio_ff", {16'h0, o_gpio}, 32'h0000_00FF);
      wr(3'd0, 32'hFFFF, 4'hF);
      rd(3'd0, 32'h0, "in_ro");

      // rising edge latency with PSC=0
      wr(3'd4, 32'h1, 4'hF);
      i_gpio[0] = 1'b1;
      cycles(3);
      check("int_early", {31'h0, o_int}, 32'h0);
      rd(3'd6, 32'h0, "pend_early");
      check("int_at4", {31'h0, o_int}, 32'h0);
      rd(3'd6, 32'h1, "pend_at4");
      check("int_at5", {31'h0, o_int}, 32'h1);
      wr(3'd6, 32'h1, 4'hF);
      check("int_w1c_reg", {31'h0, o_int}, 32'h1);
      cycles(1);
      check("int_w1c_drop", {31'h0, o_int}, 32'h0);
      rd(3'd6, 32'h0, "pend_w1c");
      rd(3'd0, 32'h1, "in_bit0");

      // edge coinciding with a W1C of the same bit
      wr(3'd4, 32'h5, 4'hF);
      i_gpio[2] = 1'b1;
      cycles(3);
      wr(3'd6, 32'h4, 4'hF);
      rd(3'd6, 32'h4, "set_wins");
      wr(3'd4, 32'h0, 4'hF);
      rd(3'd6, 32'h4, "disable_keeps");
      wr(3'd6, 32'h4, 4'hF);
      rd(3'd6, 32'h0, "pend_clr2");

      // PSC=3: 5-clock glitch straddles one tick only
      wr(3'd4, 32'h2, 4'hF);
      wr(3'd5, 32'h2, 4'hF);
      wr(3'd7, 32'h3, 4'hF);
      cycles(2);
      i_gpio[1] = 1'b1;
      cycles(5);
      i_gpio[1] = 1'b0;
      cycles(12);
      rd(3'd6, 32'h0, "glitch_pend");
      rd(3'd0, 32'h5, "glitch_in");
      rd(3'd7, 32'h3, "psc_rd");
      check("glitch_int", {31'h0, o_int}, 32'h0);
      i_gpio[1] = 1'b1;
      cycles(12);
      rd(3'd6, 32'h2, "held_pend");
      rd(3'd0, 32'h7, "held_in");
      i_gpio[1] = 1'b0;
      cycles(2);

      // reset during an outstanding write strobe
      i_wb_cyc  = 1'b1;
      i_wb_stb  = 1'b1;
      i_wb_we   = 1'b1;
      i_wb_addr = 3'd1;
      i_wb_data = 32'hFFFF;
      i_wb_sel  = 4'hF;
      #2 i_reset = 1'b1;
      @(posedge i_clk); #1;
      i_wb_cyc = 1'b0;
      i_wb_stb = 1'b0;
      i_wb_we  = 1'b0;
      check("rstmid_ack", {31'h0, o_wb_ack}, 32'h0);
      check("rstmid_gpio", {16'h0, o_gpio}, 32'h0000_00A5);
      cycles(1);
      check("rstmid_int", {31'h0, o_int}, 32'h0);
      i_reset = 1'b0;
      cycles(1);
      check("rstmid_ack2", {31'h0, o_wb_ack}, 32'h0);
      rd(3'd1, 32'h0000_00A5, "rstmid_out");
      rd(3'd4, 32'h0, "rstmid_rise");
      rd(3'd5, 32'h0, "rstmid_fall");
      rd(3'd7, 32'h0, "rstmid_psc");
      cycles(6);
      rd(3'd0, 32'h5, "post_rst_in");
      rd(3'd6, 32'h0, "post_rst_pend");
      cycles(3);
      check("post_rst_int", {31'h0, o_int}, 32'h0);
      check("sb_drained", sb.size(), 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
